// File: rtl/console_pkg.sv
// Shared console constants, arbiter state encoding and the forwarded bus payload.
package console_pkg;

  localparam int unsigned DataW = 32;

  localparam logic [7:0] CHAR_OUT_ADDR = 8'h04;
  localparam logic [7:0] SIM_CTRL_ADDR = 8'h08;
  localparam logic [7:0] CHAR_NEWLINE  = 8'h0A;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  typedef struct packed {
    logic             we;
    logic [DataW-1:0] addr;
    logic [DataW-1:0] wdata;
  } con_xfer_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority pick: first requester at or after base, wrapping.
module rr_arbiter #(
  parameter  int unsigned N    = 2,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] base,
  output logic [N-1:0]    grant,
  output logic [IdxW-1:0] idx,
  output logic            valid
);

  int unsigned pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    pos   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = (32'(base) + k) % N;
      if (!valid && req[pos[IdxW-1:0]]) begin
        valid                  = 1'b1;
        grant[pos[IdxW-1:0]]   = 1'b1;
        idx                    = pos[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/console_arbiter.sv
// Round-robin console write arbiter; a master owns the console for a whole text line.
module console_arbiter
  import console_pkg::*;
#(
  parameter int unsigned NumReq      = 2,
  parameter int unsigned LockTimeout = 256
) (
  input  logic                    clk_in,
  input  logic                    reset_n_in,
  input  logic [NumReq-1:0]       req_in,
  input  logic [NumReq-1:0]       we_in,
  input  logic [NumReq*DataW-1:0] addr_in,
  input  logic [NumReq*DataW-1:0] wdata_in,
  output logic [NumReq-1:0]       gnt_out,
  output logic                    con_req_out,
  output logic                    con_we_out,
  output logic [DataW-1:0]        con_addr_out,
  output logic [DataW-1:0]        con_wdata_out,
  output logic                    lock_out
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned CntW = (LockTimeout > 0) ? $clog2(LockTimeout + 1) : 1;

  arb_state_e      state;
  logic [IdxW-1:0] owner;
  logic [IdxW-1:0] last;
  logic [CntW-1:0] cnt;

  logic [IdxW-1:0]   base;
  logic [NumReq-1:0] owner_mask;
  logic [NumReq-1:0] eligible;
  logic [NumReq-1:0] pick;
  logic [IdxW-1:0]   pick_idx;
  logic              pick_valid;
  logic              busy;
  logic              locked;
  logic              timed_out;
  logic              hold_lock;
  con_xfer_t         sel;
  logic              sel_char;
  logic              sel_nl;
  logic              sel_sim;

  assign busy       = |gnt_out;
  assign locked     = (state == ARB_LOCKED);
  assign timed_out  = locked && (cnt == CntW'(LockTimeout));
  assign owner_mask = NumReq'(1) << owner;
  // An owner request on the timeout edge keeps the lock; otherwise expiry opens arbitration.
  assign hold_lock  = locked && (!timed_out || ((|(req_in & owner_mask)) && !busy));
  assign eligible   = busy ? '0 : (hold_lock ? (req_in & owner_mask) : req_in);
  assign base       = (last == IdxW'(NumReq - 1)) ? '0 : last + IdxW'(1);

  rr_arbiter #(.N(NumReq)) u_rr (
    .req   (eligible),
    .base  (base),
    .grant (pick),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (pick[i]) begin
        sel.we    = we_in[i];
        sel.addr  = addr_in[DataW*i +: DataW];
        sel.wdata = wdata_in[DataW*i +: DataW];
      end
    end
  end

  assign sel_char = sel.we && (sel.addr[7:0] == CHAR_OUT_ADDR);
  assign sel_nl   = sel_char && (sel.wdata[7:0] == CHAR_NEWLINE);
  assign sel_sim  = sel.we && (sel.addr[7:0] == SIM_CTRL_ADDR);

  // Line-lock FSM, rr pointer, timeout counter and registered console payload.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state         <= ARB_IDLE;
      owner         <= '0;
      last          <= '0;
      cnt           <= '0;
      gnt_out       <= '0;
      con_req_out   <= 1'b0;
      con_we_out    <= 1'b0;
      con_addr_out  <= '0;
      con_wdata_out <= '0;
    end else begin
      gnt_out     <= pick;
      con_req_out <= pick_valid;
      con_we_out  <= pick_valid & sel.we;
      if (pick_valid) begin
        con_addr_out  <= sel.addr;
        con_wdata_out <= sel.wdata;
        last          <= pick_idx;
        cnt           <= '0;
        if (hold_lock) begin
          if (sel_nl || sel_sim) state <= ARB_IDLE;
        end else if (sel_char && !sel_nl && (LockTimeout != 0)) begin
          state <= ARB_LOCKED;
          owner <= pick_idx;
        end else begin
          state <= ARB_IDLE;
        end
      end else if (hold_lock) begin
        cnt <= cnt + CntW'(1);
      end else begin
        state <= ARB_IDLE;
      end
    end
  end

  assign lock_out = (state == ARB_LOCKED);

endmodule
